e15_prog_loader: RTL and testbench

Writer-side companion to the E15 processor's 16x12 instruction ROM. It receives a program as a handshaked stream of 4-bit nibbles, assembles 12-bit instruction words, and writes them into instruction memory. It verifies a checksum, pads unused addresses with a halt word, and then releases the processor through cpu_run. It sits between a host/test source and the instruction-memory write port.

---
 rtl/e15_prog_loader_if.sv | 27 ++
 rtl/e15_prog_loader.sv | 151 +++++++++++++++
 tb/tb_e15_prog_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/e15_prog_loader_if.sv
// Nibble stream in, instruction-memory write port and status out, for the E15 program loader.
// The loader connects through the slave modport; the host/test source uses the master modport.
interface e15_prog_loader_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic              in_valid;
    logic [3:0]        in_nibble;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_run;

    modport slave (
        input  start, in_valid, in_nibble,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_run
    );

    modport master (
        output start, in_valid, in_nibble,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_run
    );
endinterface

// File: rtl/e15_prog_loader.sv
// Loads a nibble-streamed program into the E15 instruction ROM, verifies a 4-bit checksum,
// pads the unused tail with a halt word and then releases the CPU.
module e15_prog_loader #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [11:0] FILL_WORD = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    e15_prog_loader_if.slave  io_bus
);
    typedef enum logic [2:0] {
        StIdle, StCount, StData, StCheck, StFill, StDone, StError
    } state_e;

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrTop = '1;

    state_e            r_state, w_state_next;
    logic [3:0]        r_sum, w_sum_next;
    logic [ADDR_W-1:0] r_last, w_last_next;     // index of the final program word (N-1)
    logic [ADDR_W-1:0] r_addr, w_addr_next;     // word currently being assembled
    logic [1:0]        r_idx, w_idx_next;
    logic [7:0]        r_hi, w_hi_next;
    logic              r_we, w_we_next;
    logic [ADDR_W-1:0] r_waddr, w_waddr_next;
    logic [11:0]       r_wdata, w_wdata_next;

    logic       w_ready;
    logic       w_accept;
    logic [3:0] w_sum_acc;

    assign w_ready   = (r_state == StCount) || (r_state == StData) || (r_state == StCheck);
    assign w_accept  = io_bus.in_valid && w_ready;
    assign w_sum_acc = r_sum + io_bus.in_nibble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_sum   <= '0;
            r_last  <= '0;
            r_addr  <= '0;
            r_idx   <= '0;
            r_hi    <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_sum   <= w_sum_next;
            r_last  <= w_last_next;
            r_addr  <= w_addr_next;
            r_idx   <= w_idx_next;
            r_hi    <= w_hi_next;
            r_we    <= w_we_next;
            r_waddr <= w_waddr_next;
            r_wdata <= w_wdata_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sum_next   = r_sum;
        w_last_next  = r_last;
        w_addr_next  = r_addr;
        w_idx_next   = r_idx;
        w_hi_next    = r_hi;
        w_we_next    = 1'b0;
        w_waddr_next = r_waddr;
        w_wdata_next = r_wdata;

        case (r_state)
            StIdle, StDone, StError: begin
                if (io_bus.start) begin
                    w_state_next = StCount;
                    w_sum_next   = '0;
                    w_addr_next  = '0;
                    w_idx_next   = '0;
                end
            end
            StCount: begin
                if (w_accept) begin
                    // Count nibble 0 means 16 words, so N-1 wraps to 15.
                    w_last_next  = ADDR_W'(io_bus.in_nibble - 4'd1);
                    w_sum_next   = io_bus.in_nibble;
                    w_state_next = StData;
                end
            end
            StData: begin
                if (w_accept) begin
                    w_sum_next = w_sum_acc;
                    case (r_idx)
                        2'd0: begin
                            w_hi_next[7:4] = io_bus.in_nibble;
                            w_idx_next     = 2'd1;
                        end
                        2'd1: begin
                            w_hi_next[3:0] = io_bus.in_nibble;
                            w_idx_next     = 2'd2;
                        end
                        default: begin
                            w_idx_next   = 2'd0;
                            w_we_next    = 1'b1;
                            w_waddr_next = r_addr;
                            w_wdata_next = {r_hi, io_bus.in_nibble};
                            if (r_addr == r_last) begin
                                w_state_next = StCheck;
                            end else begin
                                w_addr_next = r_addr + AddrOne;
                            end
                        end
                    endcase
                end
            end
            StCheck: begin
                if (w_accept) begin
                    w_sum_next = w_sum_acc;
                    if (w_sum_acc != 4'd0) begin
                        w_state_next = StError;
                    end else if (r_last == AddrTop) begin
                        w_state_next = StDone;
                    end else begin
                        // First pad write is issued together with the check accept.
                        w_state_next = StFill;
                        w_we_next    = 1'b1;
                        w_waddr_next = r_last + AddrOne;
                        w_wdata_next = FILL_WORD;
                    end
                end
            end
            StFill: begin
                if (r_waddr == AddrTop) begin
                    w_state_next = StDone;
                end else begin
                    w_we_next    = 1'b1;
                    w_waddr_next = r_waddr + AddrOne;
                    w_wdata_next = FILL_WORD;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign io_bus.in_ready  = w_ready;
    assign io_bus.mem_we    = r_we;
    assign io_bus.mem_addr  = r_waddr;
    assign io_bus.mem_wdata = r_wdata;
    assign io_bus.busy      = w_ready || (r_state == StFill);
    assign io_bus.done      = (r_state == StDone);
    assign io_bus.err       = (r_state == StError);
    assign io_bus.cpu_run   = (r_state == StDone);
endmodule

// File: tb/tb_e15_prog_loader.sv
// Directed bench for e15_prog_loader: cycle-exact vector table for a basic load, then
// hand-written sequences for bad checksum, full program, gaps, reset and start corner cases.
module tb_e15_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    e15_prog_loader_if #(.ADDR_W(4)) bus ();

    e15_prog_loader #(.ADDR_W(4), .FILL_WORD(12'h000)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        valid;
        logic [3:0]  nib;
        logic [21:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          checks   = 0;
    int          failures = 0;
    int          wr_cnt   = 0;
    logic [11:0] sb_mem [16];
    logic [3:0]  basic [8];

    // Collect every memory write the loader issues.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            sb_mem[bus.mem_addr] = bus.mem_wdata;
            wr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] obs();
        return {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.busy, bus.done, bus.err, bus.cpu_run};
    endfunction

    function automatic vec_t mk(logic r, logic s, logic v, logic [3:0] n, logic rdy, logic we,
                                logic [3:0] a, logic [11:0] d, logic b, logic dn, logic e,
                                logic run);
        vec_t t;
        t.rst   = r;
        t.start = s;
        t.valid = v;
        t.nib   = n;
        t.exp   = {rdy, we, a, d, b, dn, e, run};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic clear_sb();
        wr_cnt = 0;
        for (int i = 0; i < 16; i++) sb_mem[i] = 12'hBAD;
    endtask

    task automatic send_nib(input logic [3:0] nib, input int gap_max, input logic st);
        int n;
        repeat ($urandom_range(gap_max, 0)) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.in_valid  = 1'b0;
            bus.in_nibble = 4'hA;
        end
        @(negedge clk);
        bus.start     = st;
        bus.in_valid  = 1'b1;
        bus.in_nibble = nib;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        if (n == 20) fail_now("accept_timeout");
        @(posedge clk);
    endtask

    task automatic send_basic(input logic [3:0] chk_nib, input int gap_max, input int start_at);
        for (int i = 0; i < 8; i++) begin
            send_nib((i == 7) ? chk_nib : basic[i], gap_max, i == start_at);
        end
    endtask

    task automatic wait_end(input string name, input int bound);
        int n = 0;
        while (!(bus.done === 1'b1 || bus.err === 1'b1) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n == bound) fail_now(name);
    endtask

    task automatic chk_basic_mem(input string name);
        chk({name, "_wr_cnt"}, wr_cnt, 16);
        chk({name, "_w0"}, sb_mem[0], 12'h915);
        for (int i = 1; i < 16; i++) chk($sformatf("%s_w%0d", name, i), sb_mem[i], 12'h000);
    endtask

    initial begin
        logic [11:0] words [16];
        logic [3:0]  sum;
        logic [3:0]  nb;

        basic[0] = 4'h2; basic[1] = 4'h9; basic[2] = 4'h1; basic[3] = 4'h5;
        basic[4] = 4'h0; basic[5] = 4'h0; basic[6] = 4'h0; basic[7] = 4'hF;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_nibble = 4'h0;
        clear_sb();

        // Basic load, cycle by cycle: inputs for the cycle and outputs seen in it.
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0, 4'd0, 12'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 0, 4'd0, 12'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h2, 1, 0, 4'd0, 12'h000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h9, 1, 0, 4'd0, 12'h000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h1, 1, 0, 4'd0, 12'h000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h5, 1, 0, 4'd0, 12'h000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h0, 1, 1, 4'd0, 12'h915, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h0, 1, 0, 4'd0, 12'h915, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'h0, 1, 0, 4'd0, 12'h915, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'hF, 1, 1, 4'd1, 12'h000, 1, 0, 0, 0));
        for (int a = 2; a < 16; a++) begin
            vecs.push_back(mk(0, 0, 1, 4'h7, 0, 1, 4'(a), 12'h000, 1, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0, 4'd15, 12'h000, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 0, 4'd15, 12'h000, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'h0, 1, 0, 4'd15, 12'h000, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.start     = vecs[i].start;
            bus.in_valid  = vecs[i].valid;
            bus.in_nibble = vecs[i].nib;
            #1;
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Bad checksum: loader already in COUNT from the restart above.
        clear_sb();
        send_basic(4'hE, 0, -1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bad_err", bus.err, 1);
        chk("bad_done", bus.done, 0);
        chk("bad_run", bus.cpu_run, 0);
        chk("bad_busy", bus.busy, 0);
        chk("bad_ready", bus.in_ready, 0);
        chk("bad_wr_cnt", wr_cnt, 2);
        chk("bad_w0", sb_mem[0], 12'h915);
        chk("bad_w1", sb_mem[1], 12'h000);
        chk("bad_w2", sb_mem[2], 12'hBAD);

        // Full 16-word program, no pad phase.
        clear_sb();
        for (int i = 0; i < 16; i++) words[i] = {4'(i), 4'(i * 5 + 1), ~4'(i)};
        @(negedge clk);
        bus.start = 1'b1;
        send_nib(4'h0, 0, 1'b0);
        sum = 4'h0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 2; k >= 0; k--) begin
                nb  = words[i][k*4 +: 4];
                sum = sum + nb;
                send_nib(nb, 0, 1'b0);
            end
        end
        send_nib(4'h0 - sum, 0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("full_done", bus.done, 1);
        chk("full_run", bus.cpu_run, 1);
        chk("full_err", bus.err, 0);
        chk("full_wr_cnt", wr_cnt, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("full_w%0d", i), sb_mem[i], words[i]);

        // Reset, nibbles offered in IDLE, then gapped stream with a start pulse mid-DATA.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_nibble = 4'h3;
        repeat (3) @(negedge clk);
        chk("idle_ready", bus.in_ready, 0);
        chk("idle_busy", bus.busy, 0);
        clear_sb();
        bus.start = 1'b1;
        send_basic(4'hF, 2, 4);
        @(negedge clk);
        bus.in_nibble = 4'h7;
        wait_end("gap_wait", 100);
        bus.in_valid = 1'b0;
        chk("gap_done", bus.done, 1);
        chk("gap_err", bus.err, 0);
        chk_basic_mem("gap");

        // Reset after the 5th accepted nibble, with start asserted alongside rst.
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) send_nib(basic[i], 0, 1'b0);
        @(negedge clk);
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_nibble = 4'h0;
        @(negedge clk);
        chk("rst_outputs", obs(), 22'h0);
        rst       = 1'b0;
        bus.start = 1'b0;
        clear_sb();
        repeat (5) @(negedge clk);
        chk("rst_no_writes", wr_cnt, 0);
        chk("rst_idle_ready", bus.in_ready, 0);
        bus.start = 1'b1;
        send_basic(4'hF, 0, -1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_end("rst_wait", 100);
        chk("rst_done", bus.done, 1);
        chk_basic_mem("rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
